// File: rtl/axi_burst_read_master.sv
// axi_burst_read_master: fetches one LINE_W-bit line as an AXI4 read burst of
// DATA_W-bit beats, assembles it into a line buffer and returns it with a
// one-cycle resp_valid pulse plus a sticky error flag.
// Optional build macro AXI_RD_CRITICAL_WORD_FIRST_EN: issue a WRAP burst that
// starts at the requested beat; beats still land in slots by address.
module axi_burst_read_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64,
    parameter int LINE_W = 256
) (
    input  logic              ACLK,
    input  logic              ARESETn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              resp_valid,
    output logic [LINE_W-1:0] resp_data,
    output logic              resp_err,
    output logic              ARVALID,
    input  logic              ARREADY,
    output logic [ADDR_W-1:0] ARADDR,
    output logic [7:0]        ARLEN,
    output logic [2:0]        ARSIZE,
    output logic [1:0]        ARBURST,
    output logic [2:0]        ARPROT,
    input  logic              RVALID,
    output logic              RREADY,
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RLAST
);
    localparam int BEATS = LINE_W / DATA_W;
    localparam int BSZ   = $clog2(DATA_W / 8);
    localparam int LSZ   = $clog2(LINE_W / 8);
    localparam int CW    = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(BEATS - 1);
    localparam logic [CW:0]   LAST_RCV = (CW+1)'(BEATS - 1);
    localparam logic [CW:0]   FULL_RCV = (CW+1)'(BEATS);

`ifdef AXI_RD_CRITICAL_WORD_FIRST_EN
    localparam int         ALIGN = BSZ;
    localparam logic [1:0] BURST = 2'b10;
`else
    localparam int         ALIGN = LSZ;
    localparam logic [1:0] BURST = 2'b01;
`endif
    localparam logic [ADDR_W-1:0] ALIGN_MASK = {ADDR_W{1'b1}} << ALIGN;

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   araddr_q;
    logic                arvalid_q;
    logic                rready_q;
    logic                resp_valid_q;
    logic                resp_err_q;
    logic [LINE_W-1:0]   line_q;
    logic [CW-1:0]       cnt_q;      // slot written by the next beat
    logic [CW:0]         rcv_q;      // beats received, saturates at BEATS
    logic                err_q;      // sticky burst error

    logic [CW-1:0]       start_d;
    logic [CW-1:0]       cnt_d;
    logic [CW:0]         rcv_d;
    logic                err_d;

    // First slot of the burst: wrap start in critical-word-first mode, else 0
`ifdef AXI_RD_CRITICAL_WORD_FIRST_EN
    assign start_d = req_addr[LSZ-1:BSZ];
`else
    assign start_d = '0;
`endif

    // Per-beat next values; err_d folds in bad RRESP and an RLAST that
    // arrives early or fails to arrive on the final beat
    always_comb begin
        cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + 1'b1;
        rcv_d = (rcv_q == FULL_RCV) ? rcv_q : rcv_q + 1'b1;
        err_d = err_q | (RRESP != 2'b00)
              | (RLAST ? (rcv_q < LAST_RCV) : (rcv_q >= LAST_RCV));
    end

    // Request FSM with all AXI and response outputs registered
    always_ff @(posedge ACLK) begin
        if (!ARESETn) begin
            state_q      <= IDLE;
            araddr_q     <= '0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            line_q       <= '0;
            cnt_q        <= '0;
            rcv_q        <= '0;
            err_q        <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        araddr_q  <= req_addr & ALIGN_MASK;
                        arvalid_q <= 1'b1;
                        cnt_q     <= start_d;
                        rcv_q     <= '0;
                        err_q     <= 1'b0;
                        state_q   <= ADDR;
                    end
                end
                ADDR: begin
                    if (ARREADY) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= DATA;
                    end
                end
                DATA: begin
                    if (RVALID && rready_q) begin
                        // Beats past the line length are dropped
                        if (rcv_q != FULL_RCV) begin
                            line_q[cnt_q*DATA_W +: DATA_W] <= RDATA;
                            cnt_q <= cnt_d;
                        end
                        rcv_q <= rcv_d;
                        err_q <= err_d;
                        if (RLAST) begin
                            rready_q     <= 1'b0;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= err_d;
                            state_q      <= RESP;
                        end
                    end
                end
                RESP: begin
                    resp_valid_q <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_data  = line_q;
    assign ARVALID    = arvalid_q;
    assign ARADDR     = araddr_q;
    assign ARLEN      = 8'(BEATS - 1);
    assign ARSIZE     = 3'(BSZ);
    assign ARBURST    = BURST;
    assign ARPROT     = 3'b000;
    assign RREADY     = rready_q;

endmodule
